// File: rtl/smp_timer_pkg.sv
// Shared constants for the SMP timer bank: register offsets, CTRL fields,
// prescaler step width and default thresholds.
package smp_timer_pkg;

    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_EN       = 5'h01;
    localparam logic [4:0] REG_IMASK    = 5'h02;
    localparam logic [4:0] REG_DIV_BASE = 5'h08;
    localparam logic [4:0] REG_OUT_BASE = 5'h10;

    localparam int CTRL_CLK_LO = 6;
    localparam int CTRL_TM_LO  = 4;
    localparam int CTRL_TM_EN  = 3;
    localparam int CTRL_TM_DIS = 0;

    localparam logic [7:0] CTRL_RST   = 8'h08;
    localparam logic [7:0] CTRL_WMASK = 8'hF9;

    localparam int STEP_W       = 5;
    localparam int DIV_W        = 8;
    localparam int SLOW_THR_DEF = 384;
    localparam int FAST_THR_DEF = 48;

    // step = (1 << clk_speed) + (2 << tm_speed), at most 24
    function automatic logic [STEP_W-1:0] step_of(
        input logic [1:0] clk_spd,
        input logic [1:0] tm_spd
    );
        return (STEP_W'(1) << clk_spd) + (STEP_W'(2) << tm_spd);
    endfunction

endpackage

// File: rtl/smp_timer_chan.sv
// One timer channel: 8-bit stage-2 divider plus wrapping output counter.
// Ports: dom_tick/active advance it, en_rise clears it, rd_clr read-clears out_o.
module smp_timer_chan
    import smp_timer_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dom_tick,
    input  logic             active,
    input  logic [DIV_W-1:0] div_i,
    input  logic             en_rise,
    input  logic             rd_clr,
    output logic [OUT_W-1:0] out_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [OUT_W-1:0] out_q, out_d;
    logic             tick_q, tick_d;
    logic             adv, inc;

    always_comb begin
        cnt_inc = cnt_q + DIV_W'(1);
        adv     = dom_tick && active;
        // 8-bit compare: div 0 matches after the wrap, i.e. divide-by-256
        inc     = adv && (cnt_inc == div_i);
        cnt_d   = cnt_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        if (adv) begin
            cnt_d = inc ? '0 : cnt_inc;
        end
        if (en_rise) begin
            cnt_d = '0;
            out_d = '0;
        end else if (rd_clr) begin
            // a coinciding increment survives the read-clear
            out_d  = inc ? OUT_W'(1) : '0;
            tick_d = inc;
        end else if (inc) begin
            out_d  = out_q + OUT_W'(1);
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            out_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign out_o  = out_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/smp_timer_bank.sv
// N-channel SMP timer bank with slow/fast shared prescalers and a byte-wide
// register port (CLK, RST_N, CE, ADDR, WR, RD, DI -> DO, TICK).
// Optional SMP_TIMER_IRQ_EN adds IMASK at 0x02 and a registered IRQ output.
module smp_timer_bank
    import smp_timer_pkg::*;
#(
    parameter int         NUM_TIMERS = 3,
    parameter int         OUT_W      = 4,
    parameter logic [7:0] FAST_MASK  = 8'b0000_0100,
    parameter int         SLOW_THR   = SLOW_THR_DEF,
    parameter int         FAST_THR   = FAST_THR_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CE,
    input  logic [4:0]            ADDR,
    input  logic                  WR,
    input  logic                  RD,
    input  logic [7:0]            DI,
    output logic [7:0]            DO,
    output logic [NUM_TIMERS-1:0] TICK
`ifdef SMP_TIMER_IRQ_EN
    ,
    output logic                  IRQ
`endif
);

    logic [7:0]            ctrl_q, ctrl_d;
    logic [NUM_TIMERS-1:0] en_q, en_d;
    logic [7:0]            div_q [NUM_TIMERS];
    logic [7:0]            div_d [NUM_TIMERS];
    logic [8:0]            slow_q, slow_d;
    logic [5:0]            fast_q, fast_d;
    logic [STEP_W-1:0]     step;
    logic [9:0]            slow_sum;
    logic [6:0]            fast_sum;
    logic                  slow_tick, fast_tick;
    logic                  wr_hit, rd_hit;
    logic [NUM_TIMERS-1:0] en_rise, rd_clr, chan_act, dom_tick;
    logic [OUT_W-1:0]      out_w  [NUM_TIMERS];
    logic                  tick_w [NUM_TIMERS];
`ifdef SMP_TIMER_IRQ_EN
    logic [NUM_TIMERS-1:0] imask_q, imask_d, out_nz;
    logic                  irq_q, irq_d;
`endif

    // prescalers: sums are one bit wider so the fast one cannot overflow
    always_comb begin
        step      = step_of(ctrl_q[CTRL_CLK_LO +: 2], ctrl_q[CTRL_TM_LO +: 2]);
        slow_sum  = {1'b0, slow_q} + 10'(step);
        fast_sum  = {1'b0, fast_q} + 7'(step);
        slow_tick = CE && (slow_sum >= 10'(SLOW_THR));
        fast_tick = CE && (fast_sum >= 7'(FAST_THR));
        slow_d    = slow_q;
        fast_d    = fast_q;
        if (CE) begin
            slow_d = slow_tick ? 9'(slow_sum - 10'(SLOW_THR)) : slow_sum[8:0];
            fast_d = fast_tick ? 6'(fast_sum - 7'(FAST_THR)) : fast_sum[5:0];
        end
    end

    // register writes and per-channel strobes; WR masks RD side effects
    always_comb begin
        wr_hit = CE && WR;
        rd_hit = CE && RD && !WR;
        ctrl_d = ctrl_q;
        en_d   = en_q;
        div_d  = div_q;
        if (wr_hit && ADDR == REG_CTRL) ctrl_d = DI & CTRL_WMASK;
        if (wr_hit && ADDR == REG_EN)   en_d   = DI[NUM_TIMERS-1:0];
        en_rise = '0;
        if (wr_hit && ADDR == REG_EN) en_rise = DI[NUM_TIMERS-1:0] & ~en_q;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (wr_hit && ADDR == REG_DIV_BASE + 5'(i)) div_d[i] = DI;
            rd_clr[i]   = rd_hit && (ADDR == REG_OUT_BASE + 5'(i));
            chan_act[i] = en_q[i] && ctrl_q[CTRL_TM_EN] && !ctrl_q[CTRL_TM_DIS];
            dom_tick[i] = FAST_MASK[i] ? fast_tick : slow_tick;
            TICK[i]     = tick_w[i];
        end
    end

    always_comb begin
        DO = '0;
        case (ADDR)
            REG_CTRL:  DO = ctrl_q;
            REG_EN:    DO = 8'(en_q);
`ifdef SMP_TIMER_IRQ_EN
            REG_IMASK: DO = 8'(imask_q);
`endif
            default:   DO = '0;
        endcase
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (ADDR == REG_DIV_BASE + 5'(i)) DO = div_q[i];
            if (ADDR == REG_OUT_BASE + 5'(i)) DO = 8'(out_w[i]);
        end
    end

`ifdef SMP_TIMER_IRQ_EN
    always_comb begin
        imask_d = imask_q;
        if (wr_hit && ADDR == REG_IMASK) imask_d = DI[NUM_TIMERS-1:0];
        for (int i = 0; i < NUM_TIMERS; i++) out_nz[i] = |out_w[i];
        irq_d = |(imask_q & out_nz);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            imask_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            imask_q <= imask_d;
            irq_q   <= irq_d;
        end
    end

    assign IRQ = irq_q;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ctrl_q <= CTRL_RST;
            en_q   <= '0;
            slow_q <= '0;
            fast_q <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) div_q[i] <= 8'hFF;
        end else begin
            ctrl_q <= ctrl_d;
            en_q   <= en_d;
            slow_q <= slow_d;
            fast_q <= fast_d;
            for (int i = 0; i < NUM_TIMERS; i++) div_q[i] <= div_d[i];
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        smp_timer_chan #(
            .OUT_W(OUT_W)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (RST_N),
            .dom_tick(dom_tick[g]),
            .active  (chan_act[g]),
            .div_i   (div_q[g]),
            .en_rise (en_rise[g]),
            .rd_clr  (rd_clr[g]),
            .out_o   (out_w[g]),
            .tick_o  (tick_w[g])
        );
    end

endmodule

// File: tb/tb_smp_timer_bank.sv
// Self-checking bench for smp_timer_bank: register table, directed timing
// sequences and randomized traffic against an arithmetic reference model.
module tb_smp_timer_bank;

    localparam int         NT   = 3;
    localparam int         OW   = 4;
    localparam logic [7:0] FM   = 8'b0000_0100;
    localparam int         STHR = 384;
    localparam int         FTHR = 48;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          CE = 1'b0;
    logic          WR = 1'b0;
    logic          RD = 1'b0;
    logic [4:0]    ADDR = '0;
    logic [7:0]    DI = '0;
    logic [7:0]    DO;
    logic [NT-1:0] TICK;
`ifdef SMP_TIMER_IRQ_EN
    logic          IRQ;
`endif

    always #5 CLK = ~CLK;

    smp_timer_bank #(
        .NUM_TIMERS(NT),
        .OUT_W     (OW),
        .FAST_MASK (FM),
        .SLOW_THR  (STHR),
        .FAST_THR  (FTHR)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CE   (CE),
        .ADDR (ADDR),
        .WR   (WR),
        .RD   (RD),
        .DI   (DI),
        .DO   (DO),
        .TICK (TICK)
`ifdef SMP_TIMER_IRQ_EN
        ,
        .IRQ  (IRQ)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // reference model: plain integer state, stepped once per clock
    logic [7:0]    m_ctrl;
    int            m_en, m_imask, m_slow, m_fast;
    int            m_cnt [NT];
    int            m_out [NT];
    int            m_div [NT];
    bit [NT-1:0]   m_tick;
    bit            m_irq;

    function automatic void model_reset();
        m_ctrl = 8'h08;
        m_en = 0; m_imask = 0; m_slow = 0; m_fast = 0;
        m_tick = '0; m_irq = 1'b0;
        for (int i = 0; i < NT; i++) begin
            m_cnt[i] = 0; m_out[i] = 0; m_div[i] = 255;
        end
    endfunction

    function automatic int m_step();
        return (1 << m_ctrl[7:6]) + (2 << m_ctrl[5:4]);
    endfunction

    function automatic bit m_active(int i);
        return ((m_en >> i) & 1) == 1 && m_ctrl[3] && !m_ctrl[0];
    endfunction

    function automatic int model_do(int a);
        if (a == 0) return int'(m_ctrl);
        if (a == 1) return m_en;
`ifdef SMP_TIMER_IRQ_EN
        if (a == 2) return m_imask;
`endif
        if (a >= 8 && a < 8 + NT) return m_div[a-8];
        if (a >= 16 && a < 16 + NT) return m_out[a-16];
        return 0;
    endfunction

    // will channel i count an increment on the next idle CE cycle?
    function automatic bit pend_inc(int i);
        int acc, thr;
        acc = FM[i] ? m_fast : m_slow;
        thr = FM[i] ? FTHR : STHR;
        return (acc + m_step() >= thr) && m_active(i)
            && ((m_cnt[i] + 1) % 256 == m_div[i]);
    endfunction

    function automatic void model_clk(bit ce, bit wr, bit rd, int a, int d);
        bit wh, rh, irq_n, st, ft, dt, inc;
        int c;
        wh = ce && wr;
        rh = ce && rd && !wr;
        irq_n = 1'b0;
        for (int i = 0; i < NT; i++)
            if (((m_imask >> i) & 1) == 1 && m_out[i] != 0) irq_n = 1'b1;
        st = 1'b0; ft = 1'b0;
        if (ce) begin
            m_slow += m_step();
            if (m_slow >= STHR) begin m_slow -= STHR; st = 1'b1; end
            m_fast += m_step();
            if (m_fast >= FTHR) begin m_fast -= FTHR; ft = 1'b1; end
        end
        for (int i = 0; i < NT; i++) begin
            dt = FM[i] ? ft : st;
            inc = 1'b0;
            if (dt && m_active(i)) begin
                c = (m_cnt[i] + 1) % 256;
                if (c == m_div[i]) begin m_cnt[i] = 0; inc = 1'b1; end
                else m_cnt[i] = c;
            end
            m_tick[i] = 1'b0;
            if (wh && a == 1 && ((d >> i) & 1) == 1 && ((m_en >> i) & 1) == 0) begin
                m_cnt[i] = 0; m_out[i] = 0;
            end else if (rh && a == 16 + i) begin
                m_out[i] = inc ? 1 : 0; m_tick[i] = inc;
            end else if (inc) begin
                m_out[i] = (m_out[i] + 1) % (1 << OW); m_tick[i] = 1'b1;
            end
        end
        if (wh) begin
            if (a == 0) m_ctrl = 8'(d & 'hF9);
            if (a == 1) m_en = d & ((1 << NT) - 1);
`ifdef SMP_TIMER_IRQ_EN
            if (a == 2) m_imask = d & ((1 << NT) - 1);
`endif
            if (a >= 8 && a < 8 + NT) m_div[a-8] = d & 255;
        end
        m_irq = irq_n;
    endfunction

    logic [7:0] dv;

    // entered and left at posedge+1
    task automatic cyc(input bit ce, input bit wr, input bit rd, input int a,
                       input int d, output logic [7:0] dout);
        CE = ce; WR = wr; RD = rd; ADDR = 5'(a); DI = 8'(d);
        #3;
        dout = DO;
        check($sformatf("do_model_a%0h", a), 32'(DO), 32'(model_do(a)));
        @(posedge CLK);
        model_clk(ce, wr, rd, a, d);
        #1;
        check("tick_model", 32'(TICK), 32'(m_tick));
`ifdef SMP_TIMER_IRQ_EN
        check("irq_model", 32'(IRQ), 32'(m_irq));
`endif
    endtask

    task automatic wr_reg(input int a, input int d);
        cyc(1'b1, 1'b1, 1'b0, a, d, dv);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 0, 0, dv);
    endtask

    task automatic peek(input int a, input int exp, input string nm);
        cyc(1'b0, 1'b0, 1'b0, a, 0, dv);
        check(nm, 32'(dv), 32'(exp));
    endtask

    task automatic do_reset();
        RST_N = 1'b0; CE = 1'b1; WR = 1'b1; RD = 1'b0; ADDR = 5'h01; DI = 8'hFF;
        @(posedge CLK);
        @(posedge CLK);
        model_reset();
        #1;
        RST_N = 1'b1; WR = 1'b0; CE = 1'b0;
        check("rst_tick", 32'(TICK), 32'd0);
    endtask

    typedef struct {
        int    a;
        bit    wr;
        int    d;
        int    exp;
        string nm;
    } vec_t;

    vec_t tv[$];
    int   tk[$];
    int   a, sel, irq_imask_exp;
    bit   found;

    initial begin
`ifdef SMP_TIMER_IRQ_EN
        irq_imask_exp = 8'h03;
`else
        irq_imask_exp = 8'h00;
`endif
        tv.push_back('{8'h00, 1'b0, 0, 8'h08, "rst_ctrl"});
        tv.push_back('{8'h01, 1'b0, 0, 8'h00, "rst_en"});
        tv.push_back('{8'h02, 1'b0, 0, 8'h00, "rst_a02"});
        tv.push_back('{8'h08, 1'b0, 0, 8'hFF, "rst_div0"});
        tv.push_back('{8'h09, 1'b0, 0, 8'hFF, "rst_div1"});
        tv.push_back('{8'h0A, 1'b0, 0, 8'hFF, "rst_div2"});
        tv.push_back('{8'h0B, 1'b0, 0, 8'h00, "rst_div_oor"});
        tv.push_back('{8'h10, 1'b0, 0, 8'h00, "rst_out0"});
        tv.push_back('{8'h11, 1'b0, 0, 8'h00, "rst_out1"});
        tv.push_back('{8'h12, 1'b0, 0, 8'h00, "rst_out2"});
        tv.push_back('{8'h13, 1'b0, 0, 8'h00, "rst_out_oor"});
        tv.push_back('{8'h1F, 1'b0, 0, 8'h00, "rst_a1f"});
        tv.push_back('{8'h05, 1'b0, 0, 8'h00, "rst_a05"});
        tv.push_back('{8'h00, 1'b1, 8'hFF, 8'hF9, "ctrl_wmask"});
        tv.push_back('{8'h00, 1'b1, 8'h08, 8'h08, "ctrl_back"});
        tv.push_back('{8'h09, 1'b1, 8'h12, 8'h12, "div1_wr"});
        tv.push_back('{8'h05, 1'b1, 8'hAA, 8'h00, "unmapped_wr"});
        tv.push_back('{8'h10, 1'b1, 8'h55, 8'h00, "out_ro"});
        tv.push_back('{8'h0B, 1'b1, 8'h77, 8'h00, "div_oor_wr"});
        tv.push_back('{8'h02, 1'b1, 8'h03, irq_imask_exp, "imask_wr"});

        do_reset();
        foreach (tv[k]) begin
            if (tv[k].wr) wr_reg(tv[k].a, tv[k].d);
            peek(tv[k].a, tv[k].exp, tv[k].nm);
        end

        // fast channel 2, DIV=4, step 3: tick every 16, OUT every 64
        do_reset();
        wr_reg(8'h0A, 4);
        wr_reg(8'h01, 8'h04);
        tk.delete();
        for (int k = 0; k < 192; k++) begin
            idle();
            if (TICK[2]) tk.push_back(k);
        end
        check("fast_npulse", 32'(tk.size()), 32'd3);
        for (int j = 1; j < tk.size(); j++)
            check("fast_period", 32'(tk[j] - tk[j-1]), 32'd64);
        peek(8'h12, 3, "fast_out3");

        // slow channel 0, DIV=0: one OUT step per 256*128 CE cycles
        wr_reg(8'h08, 0);
        wr_reg(8'h01, 8'h01);
        tk.delete();
        for (int k = 0; k < 256 * 128; k++) begin
            idle();
            if (TICK[0]) tk.push_back(k);
        end
        check("slow_npulse", 32'(tk.size()), 32'd1);
        peek(8'h10, 1, "slow_out1");

        // read of OUT[0]=5 colliding with its increment
        wr_reg(8'h08, 1);
        wr_reg(8'h01, 8'h00);
        wr_reg(8'h01, 8'h01);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            if (m_out[0] == 5 && pend_inc(0)) found = 1'b1;
            else idle();
        end
        check("coll_setup", 32'(found), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'h10, 0, dv);
        check("coll_do", 32'(dv), 32'd5);
        check("coll_tick", 32'(TICK[0]), 32'd1);
        peek(8'h10, 1, "coll_after");

        // EN 1->0 freezes, 0->1 clears
        wr_reg(8'h09, 3);
        wr_reg(8'h01, 8'h02);
        for (int k = 0; k < 6000 && m_out[1] != 7; k++) idle();
        peek(8'h11, 7, "en_out7");
        wr_reg(8'h01, 8'h00);
        for (int k = 0; k < 400; k++) idle();
        peek(8'h11, 7, "en_frozen");
        wr_reg(8'h01, 8'h02);
        peek(8'h11, 0, "en_reclr");
        for (int k = 0; k < 400; k++) idle();

`ifdef SMP_TIMER_IRQ_EN
        do_reset();
        wr_reg(8'h02, 8'h01);
        wr_reg(8'h08, 1);
        wr_reg(8'h01, 8'h01);
        for (int k = 0; k < 500 && !pend_inc(0); k++) idle();
        idle();
        check("irq_lat0", 32'(IRQ), 32'd0);
        idle();
        check("irq_set", 32'(IRQ), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'h10, 0, dv);
        check("irq_hold", 32'(IRQ), 32'd1);
        idle();
        check("irq_clr", 32'(IRQ), 32'd0);
`endif

        // randomized traffic
        do_reset();
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      a = 0;
                else if (sel == 1) a = 1;
                else if (sel == 2) a = 2;
                else if (sel < 6)  a = 8 + $urandom_range(0, 3);
                else if (sel < 9)  a = 16 + $urandom_range(0, 3);
                else               a = $urandom_range(0, 31);
                DI = 8'($urandom);
                if (a >= 8 && a < 12 && $urandom_range(0, 1) == 1) DI = 8'($urandom_range(0, 3));
                if (a == 0) begin
                    DI[0] = ($urandom_range(0, 3) == 0);
                    DI[3] = ($urandom_range(0, 3) != 0);
                end
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) == 0, a, int'(DI), dv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
